// File: rtl/buffer_reader_pkg.sv
// rtl/buffer_reader_pkg.sv - shared word layout and reader state encoding
package buffer_reader_pkg;

    localparam int WORD_W      = 35;
    localparam int TYPE_MSB    = 34;
    localparam int TYPE_LSB    = 32;
    localparam int PAYLOAD_MSB = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/buffer_reader_skid_fifo.sv
// rtl/buffer_reader_skid_fifo.sv - first-word-fall-through holding FIFO for returned buffer words
module reader_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             pop_ok;

    // Overflow is prevented upstream by the credit check, so push is never gated here.
    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_i && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/buffer_reader.sv
// rtl/buffer_reader.sv - pull-side drain of the shift-register buffer with skid FIFO and flush
module buffer_reader #(
    parameter int WORD_W       = 35,
    parameter int READ_LATENCY = 1,
    parameter int SKID_DEPTH   = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              buf_empty,
    input  logic [WORD_W-1:0] in_data,
    output logic              next_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_type,
    output logic [31:0]       out_payload,
    input  logic              flush,
    output logic              flush_done,
    output logic [CNT_W-1:0]  bubble_count
);
    import buffer_reader_pkg::*;

    localparam int FC_W  = $clog2(SKID_DEPTH) + 1;
    localparam int SUM_W = FC_W + 1;

    state_e              state_q, state_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [CNT_W-1:0]    bubble_q, bubble_d;
    logic [FC_W-1:0]     fifo_count;
    logic [FC_W-1:0]     inflight_count;
    logic [WORD_W-1:0]   head;
    logic                fifo_empty;
    logic                ret;
    logic                push;
    logic                credit_ok;

    assign ret            = pipe_q[READ_LATENCY-1];
    assign push           = ret && (in_data != '0);
    assign inflight_count = FC_W'($countones(pipe_q));
    // Outstanding requests reserve a slot, so a returning word can never overflow the FIFO.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(inflight_count)) < SUM_W'(SKID_DEPTH);

    always_comb begin
        pipe_d    = pipe_q << 1;
        pipe_d[0] = next_ready;
    end

    always_comb begin
        bubble_d = bubble_q;
        if (ret && (in_data == '0) && (bubble_q != '1)) begin
            bubble_d = bubble_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        next_ready = 1'b0;
        flush_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = DRAIN;
                end else if (!buf_empty) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // flush gates the pull combinationally so no new request leaves in the flush cycle
                next_ready = !flush && !buf_empty && credit_ok;
                if (flush) begin
                    state_d = DRAIN;
                end else if (buf_empty && (inflight_count == '0)) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if ((inflight_count == '0) && fifo_empty) begin
                    flush_done = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (!flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pipe_q   <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            pipe_q   <= pipe_d;
            bubble_q <= bubble_d;
        end
    end

    reader_skid_fifo #(
        .DEPTH (SKID_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (push),
        .push_data_i (in_data),
        .pop_i       (out_valid && out_ready),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign out_valid    = !fifo_empty;
    assign out_type     = out_valid ? head[TYPE_MSB:TYPE_LSB] : 3'd0;
    assign out_payload  = out_valid ? head[PAYLOAD_MSB:0] : 32'd0;
    assign bubble_count = bubble_q;

endmodule

// File: doc/buffer_reader.md
Name: buffer_reader

Overview:
- Consumer-side drain for the 35-bit shift-register buffer memory; the reader is the other end of its `next_ready`/`out_data` pull interface.
- Issues pull requests, captures returned words and holds them in a small skid FIFO.
- Presents words downstream on a valid/ready handshake.
- Supports a flush that stops fetching, retires in-flight words, then signals done.

Parameters:
- WORD_W, 35, width of buffer word; all-zero word means "no data".
- READ_LATENCY, 1, cycles from the edge sampling `next_ready`=1 to the edge at which `in_data` holds the returned word.
- SKID_DEPTH, 4, entries in the holding FIFO; power of two, at least READ_LATENCY+1.
- CNT_W, 8, width of the saturating bubble counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- buf_empty  input  1  buffer empty flag.
- in_data  input  WORD_W  buffer output word.
- next_ready  output  1  pull request to the buffer.
- out_valid  output  1  downstream word available.
- out_ready  input  1  downstream accept.
- out_type  output  3  in_data[34:32] of the head word.
- out_payload  output  32  in_data[31:0] of the head word.
- flush  input  1  level request to stop fetching and drain.
- flush_done  output  1  one-cycle pulse when the drain completes.
- bubble_count  output  CNT_W  saturating count of requested-but-zero returns.

Behaviour:
- Reset (reset=0, asynchronous):
  - next_ready=0, out_valid=0, out_type=0, out_payload=0, flush_done=0, bubble_count=0.
  - FIFO empty, in-flight pipe cleared, state=IDLE.
- In-flight tracking:
  - A READ_LATENCY-deep shift register records next_ready.
  - Its tail bit `ret` marks the cycle in which in_data is the answer to an earlier request.
  - in_data is ignored when ret=0.
- Capture, when ret=1:
  - in_data != 0: push into the FIFO.
  - in_data == 0: drop the word and increment bubble_count, saturating at all-ones.
- Credit rule: `next_ready` = (state==FETCH) & ~buf_empty & (fifo_count + inflight_count < SKID_DEPTH).
  - This guarantees that a returned word always has a slot; overflow is impossible by construction.
  - Pulls are never issued while buf_empty=1.
- Downstream:
  - out_valid = FIFO not empty; out_type and out_payload come from the FIFO head (registered/FWFT, no comb path from in_data).
  - A pop happens when out_valid & out_ready.
  - Simultaneous push and pop in one cycle is legal, and fifo_count is unchanged.
  - Pointers wrap modulo SKID_DEPTH.
  - With out_ready held at 1, a word returned at edge t is presented after edge t, so it is accepted at edge t+1.
- States:
  - IDLE: next_ready=0. Go to FETCH when ~buf_empty & ~flush.
  - FETCH: pulls per the credit rule. Go to DRAIN when flush=1. Return to IDLE when buf_empty & inflight_count==0 & ~flush.
  - DRAIN: next_ready=0. When inflight_count==0 and the FIFO is empty, pulse flush_done for one cycle and go to DONE.
  - DONE: hold. Go to IDLE when flush=0.
- flush asserted in IDLE goes directly to DRAIN.
- Words already in the FIFO are still delivered during DRAIN; no data is discarded.
- Mid-operation reset clears everything immediately. In-flight returns after reset release are ignored because the pipe was cleared.
- bubble_count never wraps.

Decomposition:
- Shared package holds:
  - WORD_W and the field offsets (TYPE_MSB=34, TYPE_LSB=32, PAYLOAD_MSB=31).
  - The state encoding localparams IDLE=0, FETCH=1, DRAIN=2, DONE=3.
- One sub-module: `reader_skid_fifo` (parameterised SKID_DEPTH × WORD_W, push/pop/count, async active-low reset).
- The FSM, in-flight pipe and credit logic live in the top.

Test Plan:
- Reset mid-stream: assert reset=0 with 2 words in the FIFO and 1 in flight. All outputs are 0 immediately. After release, the in-flight return 0x0_0000_0055 is ignored and out_valid stays 0.
- Basic drain:
  - Setup: buf_empty=0, buffer returns 0x1_0000_00AA then 0x2_0000_00BB, out_ready=1.
  - First-word timing: next_ready rises one cycle after reset release. The first word appears on out_valid one cycle after its return edge, with out_type=1 and out_payload=0xAA.
  - Second word: out_type=2, out_payload=0xBB.
- Backpressure: hold out_ready=0 with SKID_DEPTH=4. next_ready deasserts once fifo_count+inflight reaches 4, and there are exactly 4 words in the FIFO with no loss. Releasing out_ready delivers them in order.
- Bubbles: a requested return of 0 occurring 3 times gives bubble_count=3 and out_valid stays 0. Forcing 300 bubbles with CNT_W=8 gives bubble_count=255.
- Flush:
  - Setup: assert flush with 1 word in flight and 2 in the FIFO, out_ready=1.
  - Sequence: next_ready drops that same cycle, all 3 words are delivered, then flush_done pulses once.
  - Release: the state stays in DONE until flush=0.
- Empty gating: buf_empty=1 throughout keeps next_ready=0 for 100 cycles and the state stays IDLE.
